object_table_writer: RTL and testbench

Downstream stage of the draw-to-storage converter. It accepts one converted object per handshake and packs it into a 115-bit record. It allocates the lowest free slot in an on-chip object table and writes the record there. It exposes a registered random-access read port, an occupancy bitmap, and delete/clear commands for the physics update loop.

---
 rtl/object_pkg.sv | 23 ++
 rtl/free_slot_finder.sv | 24 ++
 rtl/object_table_writer.sv | 182 ++++++++++++++++++
 tb/tb_object_table_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/object_pkg.sv
// Shared types for the object table: packed record layout, record width and shape ids.
// No logic; no latency or backpressure of its own.
// Record fields are MSB first in converter port order.
package object_pkg;

    localparam int OBJ_RECORD_W = 115;

    localparam logic [1:0] ID_NONE   = 2'd0;
    localparam logic [1:0] ID_CIRCLE = 2'd1;
    localparam logic [1:0] ID_LINE   = 2'd2;
    localparam logic [1:0] ID_RECT   = 2'd3;

    typedef struct packed {
        logic        is_static;
        logic [1:0]  id;
        logic [47:0] params;
        logic [15:0] pos_x;
        logic [15:0] pos_y;
        logic [15:0] vel_x;
        logic [15:0] vel_y;
    } obj_record_t;

endpackage

// File: rtl/free_slot_finder.sv
// Finds the lowest clear bit of the occupancy bitmap.
// Purely combinational, zero latency; no backpressure.
module free_slot_finder #(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_occ,
    output logic [IDX_W-1:0] o_free_idx,
    output logic             o_any_free
);

    // Scan downward so the last hit written is the lowest free index.
    always_comb begin
        o_free_idx = '0;
        o_any_free = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!i_occ[i]) begin
                o_free_idx = IDX_W'(i);
                o_any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/object_table_writer.sv
// Packs converted objects into records and stores them in the lowest free table slot.
// Latency: accept_out 2 cycles after valid_in sample; reads 1 cycle. ready_out low in COMMIT/CLEAR.
// Optional OBJ_DUP_FILTER_EN drops a record identical to the last accepted one.
module object_table_writer
    import object_pkg::*;
#(
    parameter  int MAX_OBJECTS = 16,
    localparam int IDX_W       = $clog2(MAX_OBJECTS)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_in,
    input  logic                    is_static_in,
    input  logic [1:0]              id_bits_in,
    input  logic [47:0]             params_in,
    input  logic [15:0]             pos_x_in,
    input  logic [15:0]             pos_y_in,
    input  logic [15:0]             vel_x_in,
    input  logic [15:0]             vel_y_in,
    output logic                    ready_out,
    input  logic                    clear_in,
    input  logic                    del_valid_in,
    input  logic [IDX_W-1:0]        del_idx_in,
    input  logic [IDX_W-1:0]        rd_idx_in,
    output logic [OBJ_RECORD_W-1:0] rd_data_out,
    output logic                    rd_occupied_out,
    output logic                    accept_out,
    output logic [IDX_W-1:0]        accept_idx_out,
    output logic                    drop_out,
    output logic [IDX_W:0]          count_out,
    output logic                    full_out
);

    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_CLEAR} state_t;

    state_t             r_state;
    logic [MAX_OBJECTS-1:0] r_occ;
    logic [CNT_W-1:0]   r_count;
    obj_record_t        r_rec;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_sweep;
    logic               r_accept;
    logic [IDX_W-1:0]   r_accept_idx;
    logic               r_drop;
    obj_record_t        r_rd_data;
    logic               r_rd_occ;
    obj_record_t        r_mem [MAX_OBJECTS];

    obj_record_t        w_in_rec;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_any_free;
    logic               w_del_hit;
    logic               w_dup;
    logic               w_reject;
    logic               w_we;
    logic [IDX_W-1:0]   w_waddr;
    obj_record_t        w_wdata;

    assign w_in_rec = {is_static_in, id_bits_in, params_in, pos_x_in, pos_y_in, vel_x_in, vel_y_in};

    free_slot_finder #(.N(MAX_OBJECTS)) u_finder (
        .i_occ      (r_occ),
        .o_free_idx (w_free_idx),
        .o_any_free (w_any_free)
    );

`ifdef OBJ_DUP_FILTER_EN
    obj_record_t r_last_rec;
    logic        r_last_vld;
    assign w_dup = r_last_vld && (w_in_rec == r_last_rec);
`else
    assign w_dup = 1'b0;
`endif

    // Deleting an empty slot is a no-op; the sweep owns the bitmap during CLEAR.
    assign w_del_hit = del_valid_in && r_occ[del_idx_in] && (r_state != ST_CLEAR);
    assign w_reject  = (id_bits_in == ID_NONE) || !w_any_free || w_dup;

    assign w_we    = (r_state == ST_COMMIT) || (r_state == ST_CLEAR);
    assign w_waddr = (r_state == ST_COMMIT) ? r_idx : r_sweep;
    assign w_wdata = (r_state == ST_COMMIT) ? r_rec : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_occ        <= '0;
            r_count      <= '0;
            r_rec        <= '0;
            r_idx        <= '0;
            r_sweep      <= '0;
            r_accept     <= 1'b0;
            r_accept_idx <= '0;
            r_drop       <= 1'b0;
`ifdef OBJ_DUP_FILTER_EN
            r_last_rec   <= '0;
            r_last_vld   <= 1'b0;
`endif
        end else begin
            r_accept <= 1'b0;
            r_drop   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clear_in) begin
                        r_state <= ST_CLEAR;
                        r_sweep <= '0;
`ifdef OBJ_DUP_FILTER_EN
                        r_last_vld <= 1'b0;
`endif
                    end else begin
                        if (w_del_hit) begin
                            r_occ[del_idx_in] <= 1'b0;
                            r_count           <= r_count - CNT_W'(1);
                        end
                        // Free index comes from the pre-delete bitmap.
                        if (valid_in) begin
                            if (w_reject) begin
                                r_drop <= 1'b1;
                            end else begin
                                r_rec   <= w_in_rec;
                                r_idx   <= w_free_idx;
                                r_state <= ST_COMMIT;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    r_occ[r_idx] <= 1'b1;
                    if (w_del_hit) begin
                        r_occ[del_idx_in] <= 1'b0;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    r_accept     <= 1'b1;
                    r_accept_idx <= r_idx;
                    r_state      <= ST_IDLE;
`ifdef OBJ_DUP_FILTER_EN
                    r_last_rec   <= r_rec;
                    r_last_vld   <= 1'b1;
`endif
                end
                ST_CLEAR: begin
                    r_occ[r_sweep] <= 1'b0;
                    r_sweep        <= r_sweep + IDX_W'(1);
                    if (r_sweep == IDX_W'(MAX_OBJECTS - 1)) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Table storage is not reset; a reset cycle suppresses any pending write.
    always_ff @(posedge clk_in) begin
        if (!rst_in && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rd_data <= '0;
            r_rd_occ  <= 1'b0;
        end else begin
            r_rd_data <= r_mem[rd_idx_in];
            r_rd_occ  <= r_occ[rd_idx_in];
        end
    end

    assign ready_out       = (r_state == ST_IDLE) && !clear_in;
    assign rd_data_out     = r_rd_data;
    assign rd_occupied_out = r_rd_occ;
    assign accept_out      = r_accept;
    assign accept_idx_out  = r_accept_idx;
    assign drop_out        = r_drop;
    assign count_out       = r_count;
    assign full_out        = (r_count == CNT_W'(MAX_OBJECTS));

endmodule

// File: tb/tb_object_table_writer.sv
// Directed bench for object_table_writer: allocation, drops, full table, delete, clear,
// read-first behaviour and the optional duplicate filter.
module tb_object_table_writer;
    import object_pkg::*;

    localparam int MAX = 16;
    localparam int IW  = 4;

    logic         clk = 1'b0;
    logic         rst_in, valid_in, is_static_in, clear_in, del_valid_in;
    logic [1:0]   id_bits_in;
    logic [47:0]  params_in;
    logic [15:0]  pos_x_in, pos_y_in, vel_x_in, vel_y_in;
    logic [IW-1:0] del_idx_in, rd_idx_in;
    logic         ready_out, rd_occupied_out, accept_out, drop_out, full_out;
    logic [114:0] rd_data_out;
    logic [IW-1:0] accept_idx_out;
    logic [IW:0]  count_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    object_table_writer #(.MAX_OBJECTS(MAX)) dut (
        .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .is_static_in(is_static_in),
        .id_bits_in(id_bits_in), .params_in(params_in), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
        .vel_x_in(vel_x_in), .vel_y_in(vel_y_in), .ready_out(ready_out), .clear_in(clear_in),
        .del_valid_in(del_valid_in), .del_idx_in(del_idx_in), .rd_idx_in(rd_idx_in),
        .rd_data_out(rd_data_out), .rd_occupied_out(rd_occupied_out), .accept_out(accept_out),
        .accept_idx_out(accept_idx_out), .drop_out(drop_out), .count_out(count_out),
        .full_out(full_out)
    );

    function automatic logic [114:0] exp_rec(input logic st, input logic [1:0] id, input logic [15:0] px);
        return {st, id, 32'hCAFE_0000, px, px, px ^ 16'h00FF, 16'h0010, 16'hFFF0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_obj(input logic st, input logic [1:0] id, input logic [15:0] px);
        is_static_in = st;
        id_bits_in   = id;
        params_in    = {32'hCAFE_0000, px};
        pos_x_in     = px;
        pos_y_in     = px ^ 16'h00FF;
        vel_x_in     = 16'h0010;
        vel_y_in     = 16'hFFF0;
    endtask

    // Presents one object for a single cycle; after return the FSM is in COMMIT or drop_out is up.
    task automatic send_obj(input logic st, input logic [1:0] id, input logic [15:0] px);
        set_obj(st, id, px);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic apply_reset;
        rst_in = 1'b1; valid_in = 1'b0; clear_in = 1'b0; del_valid_in = 1'b0;
        del_idx_in = '0; rd_idx_in = '0;
        set_obj(1'b0, ID_NONE, 16'h0000);
        repeat (3) tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", ready_out); end
        n_checks++; if (count_out !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_out); end
        n_checks++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", full_out); end
        n_checks++; if (accept_out !== 1'b0 || drop_out !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got acc=%0b drop=%0b want 0/0", accept_out, drop_out); end
        n_checks++; if (accept_idx_out !== 4'd0) begin n_fail++; $display("FAIL reset_acc_idx: got %0d want 0", accept_idx_out); end
        n_checks++; if (rd_data_out !== 115'd0 || rd_occupied_out !== 1'b0) begin n_fail++; $display("FAIL reset_read: got data=%0h occ=%0b want 0/0", rd_data_out, rd_occupied_out); end
    endtask

    task automatic test_circles;
        for (int i = 0; i < 3; i++) begin
            send_obj(1'b0, ID_CIRCLE, 16'(100 * (i + 1)));
            n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL circle_busy%0d: got ready=%0b want 0", i, ready_out); end
            tick();
            n_checks++; if (accept_out !== 1'b1 || accept_idx_out !== 4'(i)) begin n_fail++; $display("FAIL circle_accept%0d: got acc=%0b idx=%0d want 1/%0d", i, accept_out, accept_idx_out, i); end
        end
        tick();
        n_checks++; if (accept_out !== 1'b0) begin n_fail++; $display("FAIL accept_pulse_width: got %0b want 0", accept_out); end
        n_checks++; if (count_out !== 5'd3) begin n_fail++; $display("FAIL circle_count: got %0d want 3", count_out); end
        rd_idx_in = 4'd1;
        tick();
        n_checks++; if (rd_data_out[63:48] !== 16'd200 || rd_occupied_out !== 1'b1) begin n_fail++; $display("FAIL read_idx1: got pos_x=%0d occ=%0b want 200/1", rd_data_out[63:48], rd_occupied_out); end
        n_checks++; if (rd_data_out !== exp_rec(1'b0, ID_CIRCLE, 16'd200)) begin n_fail++; $display("FAIL read_idx1_rec: got %0h want %0h", rd_data_out, exp_rec(1'b0, ID_CIRCLE, 16'd200)); end
    endtask

    task automatic test_drop_none;
        send_obj(1'b1, ID_NONE, 16'd7);
        n_checks++; if (drop_out !== 1'b1) begin n_fail++; $display("FAIL none_drop: got %0b want 1", drop_out); end
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL none_stay_idle: got ready=%0b want 1", ready_out); end
        tick();
        n_checks++; if (accept_out !== 1'b0 || drop_out !== 1'b0) begin n_fail++; $display("FAIL none_after: got acc=%0b drop=%0b want 0/0", accept_out, drop_out); end
        n_checks++; if (count_out !== 5'd3) begin n_fail++; $display("FAIL none_count: got %0d want 3", count_out); end
    endtask

    task automatic test_full;
        for (int i = 3; i < MAX; i++) begin
            send_obj(1'b0, ID_RECT, 16'(500 + i));
            tick();
            n_checks++; if (accept_out !== 1'b1 || accept_idx_out !== 4'(i)) begin n_fail++; $display("FAIL fill%0d: got acc=%0b idx=%0d want 1/%0d", i, accept_out, accept_idx_out, i); end
        end
        n_checks++; if (full_out !== 1'b1 || count_out !== 5'd16) begin n_fail++; $display("FAIL full_flag: got full=%0b count=%0d want 1/16", full_out, count_out); end
        send_obj(1'b0, ID_LINE, 16'd999);
        n_checks++; if (drop_out !== 1'b1) begin n_fail++; $display("FAIL full_drop: got %0b want 1", drop_out); end
        tick();
        n_checks++; if (accept_out !== 1'b0 || count_out !== 5'd16) begin n_fail++; $display("FAIL full_no_accept: got acc=%0b count=%0d want 0/16", accept_out, count_out); end
        del_valid_in = 1'b1; del_idx_in = 4'd5;
        tick();
        del_valid_in = 1'b0;
        n_checks++; if (count_out !== 5'd15 || full_out !== 1'b0) begin n_fail++; $display("FAIL del5_count: got count=%0d full=%0b want 15/0", count_out, full_out); end
        send_obj(1'b0, ID_LINE, 16'd999);
        tick();
        n_checks++; if (accept_out !== 1'b1 || accept_idx_out !== 4'd5) begin n_fail++; $display("FAIL reuse5: got acc=%0b idx=%0d want 1/5", accept_out, accept_idx_out); end
        n_checks++; if (count_out !== 5'd16) begin n_fail++; $display("FAIL reuse5_count: got %0d want 16", count_out); end
    endtask

    task automatic test_del_same_cycle;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            send_obj(1'b0, ID_CIRCLE, 16'(1000 + i));
            tick();
        end
        set_obj(1'b0, ID_RECT, 16'h0500);
        valid_in = 1'b1; del_valid_in = 1'b1; del_idx_in = 4'd2;
        tick();
        valid_in = 1'b0; del_valid_in = 1'b0;
        n_checks++; if (count_out !== 5'd4) begin n_fail++; $display("FAIL idle_del_count: got %0d want 4", count_out); end
        tick();
        n_checks++; if (accept_out !== 1'b1 || accept_idx_out !== 4'd5) begin n_fail++; $display("FAIL idle_del_slot: got acc=%0b idx=%0d want 1/5", accept_out, accept_idx_out); end
        n_checks++; if (count_out !== 5'd5) begin n_fail++; $display("FAIL idle_del_net: got %0d want 5", count_out); end
        // Commit into freed slot 2 while deleting slot 0 and reading slot 2.
        send_obj(1'b0, ID_LINE, 16'h0600);
        del_valid_in = 1'b1; del_idx_in = 4'd0; rd_idx_in = 4'd2;
        tick();
        del_valid_in = 1'b0;
        n_checks++; if (accept_out !== 1'b1 || accept_idx_out !== 4'd2 || count_out !== 5'd5) begin n_fail++; $display("FAIL commit_del: got acc=%0b idx=%0d count=%0d want 1/2/5", accept_out, accept_idx_out, count_out); end
        n_checks++; if (rd_data_out !== exp_rec(1'b0, ID_CIRCLE, 16'd1002) || rd_occupied_out !== 1'b0) begin n_fail++; $display("FAIL read_first: got %0h occ=%0b want %0h/0", rd_data_out, rd_occupied_out, exp_rec(1'b0, ID_CIRCLE, 16'd1002)); end
        tick();
        n_checks++; if (rd_data_out !== exp_rec(1'b0, ID_LINE, 16'h0600) || rd_occupied_out !== 1'b1) begin n_fail++; $display("FAIL read_new: got %0h occ=%0b want %0h/1", rd_data_out, rd_occupied_out, exp_rec(1'b0, ID_LINE, 16'h0600)); end
        rd_idx_in = 4'd0;
        tick();
        n_checks++; if (rd_occupied_out !== 1'b0) begin n_fail++; $display("FAIL commit_del_bit: got %0b want 0", rd_occupied_out); end
    endtask

    task automatic test_clear;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            send_obj(1'b1, ID_RECT, 16'(2000 + i));
            tick();
        end
        n_checks++; if (count_out !== 5'd10) begin n_fail++; $display("FAIL clear_pre_count: got %0d want 10", count_out); end
        clear_in = 1'b1;
        set_obj(1'b0, ID_CIRCLE, 16'd42);
        valid_in = 1'b1;
        #1;
        n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL clear_req_ready: got %0b want 0", ready_out); end
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < MAX; i++) begin
            if (i == 3) clear_in = 1'b0;
            n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL clear_busy%0d: got ready=%0b want 0", i, ready_out); end
            tick();
        end
        n_checks++; if (ready_out !== 1'b1 || count_out !== 5'd0) begin n_fail++; $display("FAIL clear_done: got ready=%0b count=%0d want 1/0", ready_out, count_out); end
        n_checks++; if (accept_out !== 1'b0 || drop_out !== 1'b0) begin n_fail++; $display("FAIL clear_silent: got acc=%0b drop=%0b want 0/0", accept_out, drop_out); end
        for (int i = 0; i < MAX; i++) begin
            rd_idx_in = 4'(i);
            tick();
            n_checks++; if (rd_occupied_out !== 1'b0 || rd_data_out !== 115'd0) begin n_fail++; $display("FAIL clear_slot%0d: got occ=%0b data=%0h want 0/0", i, rd_occupied_out, rd_data_out); end
        end
    endtask

    task automatic test_dup;
        apply_reset();
        send_obj(1'b0, ID_CIRCLE, 16'd77);
        tick();
        n_checks++; if (accept_out !== 1'b1 || accept_idx_out !== 4'd0) begin n_fail++; $display("FAIL dup_first: got acc=%0b idx=%0d want 1/0", accept_out, accept_idx_out); end
        send_obj(1'b0, ID_CIRCLE, 16'd77);
`ifdef OBJ_DUP_FILTER_EN
        n_checks++; if (drop_out !== 1'b1) begin n_fail++; $display("FAIL dup_drop: got %0b want 1", drop_out); end
        tick();
        n_checks++; if (accept_out !== 1'b0 || count_out !== 5'd1) begin n_fail++; $display("FAIL dup_no_accept: got acc=%0b count=%0d want 0/1", accept_out, count_out); end
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        repeat (MAX) tick();
        send_obj(1'b0, ID_CIRCLE, 16'd77);
        tick();
        n_checks++; if (accept_out !== 1'b1 || accept_idx_out !== 4'd0) begin n_fail++; $display("FAIL dup_after_clear: got acc=%0b idx=%0d want 1/0", accept_out, accept_idx_out); end
`else
        n_checks++; if (drop_out !== 1'b0) begin n_fail++; $display("FAIL dup_nofilter_drop: got %0b want 0", drop_out); end
        tick();
        n_checks++; if (accept_out !== 1'b1 || accept_idx_out !== 4'd1 || count_out !== 5'd2) begin n_fail++; $display("FAIL dup_second_slot: got acc=%0b idx=%0d count=%0d want 1/1/2", accept_out, accept_idx_out, count_out); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_circles();
        test_drop_none();
        test_full();
        test_del_same_cycle();
        test_clear();
        test_dup();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
